// File: rtl/sev_seg_scan_driver_if.sv
// Display-side bundle of the seven-segment scanner: per-digit glyph/control
// inputs from the elevator controller and the registered panel pin outputs.
interface sev_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [5*NUM_DIGITS-1:0] digit_codes;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_en;
    logic [NUM_DIGITS-1:0]   dp_en;
    logic [6:0]              segments;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   select;
    logic                    frame_start;

    modport master (
        output digit_codes, digit_en, blink_en, dp_en,
        input  segments, dp, select, frame_start
    );

    modport slave (
        input  digit_codes, digit_en, blink_en, dp_en,
        output segments, dp, select, frame_start
    );
endinterface

// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with a refresh
// prescaler, frame-latched glyph shadows, per-digit blanking/blink and decimal point.
module sev_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    sev_seg_scan_driver_if.slave disp
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRESC = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_FRAMES - 1);

    // Active-low glyph table; unused codes are blank.
    function automatic logic [6:0] decode_glyph(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'h00:   seg = 7'h40;
            5'h01:   seg = 7'h79;
            5'h02:   seg = 7'h24;
            5'h03:   seg = 7'h30;
            5'h04:   seg = 7'h19;
            5'h05:   seg = 7'h12;
            5'h06:   seg = 7'h02;
            5'h07:   seg = 7'h78;
            5'h08:   seg = 7'h00;
            5'h09:   seg = 7'h10;
            5'h0A:   seg = 7'h08;
            5'h0B:   seg = 7'h03;
            5'h0C:   seg = 7'h46;
            5'h0D:   seg = 7'h21;
            5'h0E:   seg = 7'h06;
            5'h0F:   seg = 7'h0E;
            5'h10:   seg = 7'b0100011;
            5'h11:   seg = 7'b1000011;
            5'h12:   seg = 7'b0111111;
            5'h13:   seg = 7'b1011100;
            5'h14:   seg = 7'b1100011;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_index;
    logic [5*NUM_DIGITS-1:0] r_sh_code;
    logic [NUM_DIGITS-1:0]   r_sh_en;
    logic [NUM_DIGITS-1:0]   r_sh_blink;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [BW-1:0]           r_blink_cnt;
    logic                    r_blink_phase;
    logic [6:0]              r_segments;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_select;
    logic                    r_frame_start;

    logic                    w_tick;
    logic                    w_load;
    logic                    w_visible;
    logic [6:0]              w_segments;
    logic                    w_dp;
    logic [NUM_DIGITS-1:0]   w_select;

    // Scan timing and the next-cycle pin values for the digit currently indexed.
    always_comb begin
        w_tick     = (r_presc == LAST_PRESC);
        w_load     = w_tick && (r_index == LAST_IDX);
        w_visible  = r_sh_en[r_index] && !(r_sh_blink[r_index] && r_blink_phase);
        w_select   = '1;
        w_segments = 7'h7F;
        w_dp       = 1'b1;
        if (w_visible) begin
            w_segments = decode_glyph(r_sh_code[5*int'(r_index) +: 5]);
            w_dp       = !r_sh_dp[r_index];
        end else begin
            w_segments = 7'h7F;
            w_dp       = 1'b1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_select[i] = !(w_visible && (r_index == IW'(i)));
        end
    end

    // Prescaler, digit index, frame shadows, blink timing and registered pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc       <= '0;
            r_index       <= LAST_IDX;
            r_sh_code     <= '0;
            r_sh_en       <= '0;
            r_sh_blink    <= '0;
            r_sh_dp       <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_segments    <= 7'h7F;
            r_dp          <= 1'b1;
            r_select      <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_presc       <= w_tick ? '0 : r_presc + PW'(1);
            r_segments    <= w_segments;
            r_dp          <= w_dp;
            r_select      <= w_select;
            r_frame_start <= w_load;
            if (w_tick) begin
                r_index <= (r_index == LAST_IDX) ? '0 : r_index + IW'(1);
            end
            // Inputs are sampled only at the frame boundary so a frame never tears.
            if (w_load) begin
                r_sh_code  <= disp.digit_codes;
                r_sh_en    <= disp.digit_en;
                r_sh_blink <= disp.blink_en;
                r_sh_dp    <= disp.dp_en;
                if (r_blink_cnt == LAST_BLINK) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= !r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
        end
    end

    assign disp.segments    = r_segments;
    assign disp.dp          = r_dp;
    assign disp.select      = r_select;
    assign disp.frame_start = r_frame_start;
endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Bench for sev_seg_scan_driver: cycle scoreboard from a timing model plus
// glyph vector table and hand-written scan/blink/reset sequences.
module tb_sev_seg_scan_driver;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int BF = 2;

    typedef struct {
        logic [4:0] code;
        logic [6:0] seg;
    } glyph_vec_t;

    typedef struct {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    glyph_vec_t vecs[32];
    exp_t       q[$];

    // Model state (spec-level view of the scanner).
    int         n, nl, cur_idx;
    logic [19:0] m_code;
    logic [3:0]  m_en, m_blink, m_dp;
    logic        m_phase;
    logic [6:0]  last_dig0;
    bit          lit[8];

    sev_seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    sev_seg_scan_driver #(
        .NUM_DIGITS  (N),
        .CLK_DIV     (D),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .disp (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // One clock: predict outputs at the edge, compare at the following negedge.
    task automatic cyc();
        exp_t e;
        exp_t g;
        logic vis;
        @(posedge clk);
        if (reset) begin
            e = '{seg: 7'h7F, dp: 1'b1, sel: 4'hF, fs: 1'b0};
            n = 0; nl = 0; cur_idx = N - 1;
            m_code = '0; m_en = '0; m_blink = '0; m_dp = '0; m_phase = 1'b0;
        end else begin
            vis   = m_en[cur_idx] && !(m_blink[cur_idx] && m_phase);
            e.sel = vis ? ~(4'b0001 << cur_idx) : 4'hF;
            e.seg = vis ? vecs[m_code[cur_idx*5 +: 5]].seg : 7'h7F;
            e.dp  = vis ? !m_dp[cur_idx] : 1'b1;
            n++;
            e.fs  = ((n % D) == 0) && ((((N - 1) + n / D) % N) == 0);
            if (e.fs) begin
                m_code = bus.digit_codes; m_en = bus.digit_en;
                m_blink = bus.blink_en; m_dp = bus.dp_en;
                nl++;
                m_phase = ((nl / BF) % 2) == 1;
            end
            cur_idx = ((N - 1) + n / D) % N;
        end
        q.push_back(e);
        @(negedge clk);
        g = q.pop_front();
        checks++;
        if (bus.segments !== g.seg || bus.dp !== g.dp || bus.select !== g.sel || bus.frame_start !== g.fs) begin
            failures++;
            $display("FAIL scan t=%0t: got seg=%h dp=%b sel=%b fs=%b expected seg=%h dp=%b sel=%b fs=%b",
                     $time, bus.segments, bus.dp, bus.select, bus.frame_start, g.seg, g.dp, g.sel, g.fs);
        end
        if (bus.select === 4'b1110) last_dig0 = bus.segments;
    endtask

    task automatic wait_fs(input string name, output int k);
        bit found = 1'b0;
        k = 0;
        while (!found && k < 64) begin
            cyc();
            k++;
            found = (bus.frame_start === 1'b1);
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s: frame_start not seen within 64 cycles", name);
        end
    endtask

    initial begin
        logic [6:0] seg_list [32] = '{
            7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
            7'b0100011, 7'b1000011, 7'b0111111, 7'b1011100, 7'b1100011, 7'h7F, 7'h7F, 7'h7F,
            7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        logic [3:0] scan_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] scan_seg [4] = '{7'h79, 7'h30, 7'b0100011, 7'b1000011};
        int k;
        for (int i = 0; i < 32; i++) vecs[i] = '{code: 5'(i), seg: seg_list[i]};

        bus.digit_codes = '0; bus.digit_en = '0; bus.blink_en = '0; bus.dp_en = '0;
        last_dig0 = 7'h7F;
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;

        // First load timing and frame period.
        wait_fs("first_fs", k);
        chk("first_fs_cycle", k, 4);
        wait_fs("fs_period", k);
        chk("fs_period", k, 16);

        // Scan order with mixed glyphs.
        bus.digit_codes = {5'h11, 5'h10, 5'h03, 5'h01};
        bus.digit_en    = 4'hF;
        wait_fs("scan_fs", k);
        for (int s = 0; s < 4; s++) begin
            repeat (4) cyc();
            chk($sformatf("scan_sel%0d", s), bus.select, scan_sel[s]);
            chk($sformatf("scan_seg%0d", s), bus.segments, scan_seg[s]);
        end

        // Mid-frame code change is held off until the next frame.
        wait_fs("tear_fs", k);
        repeat (9) cyc();
        chk("tear_slot2", bus.select, 4'b1011);
        bus.digit_codes[4:0] = 5'h0F;
        wait_fs("tear_fs2", k);
        chk("tear_old_dig0", last_dig0, 7'h79);
        repeat (2) cyc();
        chk("tear_new_dig0", bus.segments, 7'h0E);

        // Blanked digit 2.
        bus.digit_en = 4'b1011;
        wait_fs("en_fs", k);
        wait_fs("en_fs2", k);
        repeat (10) cyc();
        chk("blank_sel", bus.select, 4'b1111);
        chk("blank_seg", bus.segments, 7'h7F);
        repeat (4) cyc();
        chk("after_blank_sel", bus.select, 4'b0111);

        // Blink on digit 0, decimal point on digit 1.
        bus.digit_en = 4'hF; bus.blink_en = 4'b0001; bus.dp_en = 4'b0010;
        wait_fs("blink_fs", k);
        for (int f = 0; f < 8; f++) begin
            wait_fs("blink_frame", k);
            repeat (2) cyc();
            lit[f] = (bus.select === 4'b1110);
            chk("blink_dp_off", bus.dp, 1'b1);
            repeat (4) cyc();
            chk("dig1_lit", bus.select, 4'b1101);
            chk("dig1_dp", bus.dp, 1'b0);
        end
        for (int f = 0; f < 6; f++) chk($sformatf("blink_alt%0d", f), lit[f + 2], !lit[f]);
        chk("blink_pairs", (lit[0] == lit[1]) || (lit[1] == lit[2]), 1'b1);

        // Table of glyph vectors on every digit.
        bus.blink_en = '0; bus.dp_en = '0;
        for (int i = 0; i < 32; i++) begin
            bus.digit_codes = {4{vecs[i].code}};
            wait_fs("vec_fs", k);
            repeat (2) cyc();
            chk($sformatf("glyph_%02h", vecs[i].code), bus.segments, vecs[i].seg);
        end

        // Reset mid-frame, then restart.
        bus.digit_codes = {4{5'h1A}};
        wait_fs("rst_fs", k);
        repeat (9) cyc();
        reset = 1'b1;
        cyc();
        chk("rst_sel", bus.select, 4'hF);
        chk("rst_seg", bus.segments, 7'h7F);
        reset = 1'b0;
        wait_fs("rst_first_fs", k);
        chk("rst_first_fs_cycle", k, D);
        repeat (2) cyc();
        chk("code1a_sel", bus.select, 4'b1110);
        chk("code1a_seg", bus.segments, 7'h7F);
        repeat (20) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
